// File: rtl/rggen_register_access_adapter.sv
// Register access adapter: turns one valid/ready bus request into a single
// register access broadcast to all slices, then returns one response.
// Only one access is outstanding at any time.
module rggen_register_access_adapter #(
    parameter int                   ADDRESS_WIDTH     = 8,
    parameter int                   BUS_WIDTH         = 32,
    parameter int                   REGISTER_COUNT    = 1,
    parameter int                   ERROR_STATUS      = 1,
    parameter int                   TIMEOUT           = 0,
    parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_req_valid,
    output logic                                o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0]            i_req_address,
    input  logic                                i_req_write,
    input  logic [BUS_WIDTH-1:0]                i_req_data,
    input  logic [BUS_WIDTH/8-1:0]              i_req_strobe,
    output logic                                o_rsp_valid,
    input  logic                                i_rsp_ready,
    output logic [BUS_WIDTH-1:0]                o_rsp_data,
    output logic [1:0]                          o_rsp_status,
    output logic                                o_reg_valid,
    output logic [ADDRESS_WIDTH-1:0]            o_reg_address,
    output logic                                o_reg_write,
    output logic [BUS_WIDTH-1:0]                o_reg_data,
    output logic [BUS_WIDTH/8-1:0]              o_reg_strobe,
    input  logic [REGISTER_COUNT-1:0]           i_reg_active,
    input  logic [REGISTER_COUNT-1:0]           i_reg_ready,
    input  logic [2*REGISTER_COUNT-1:0]         i_reg_status,
    input  logic [BUS_WIDTH*REGISTER_COUNT-1:0] i_reg_data
);

    localparam int STRB_W = BUS_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN  = (TIMEOUT != 0);
    localparam bit ERR_EN = (ERROR_STATUS != 0);

    // Last counter value before the timeout fires; unused when TO_EN is 0.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_OKAY   = 2'b00;
    localparam logic [1:0] ST_SLVERR = 2'b10;
    localparam logic [1:0] ST_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic                     r_req_ready;
    logic                     r_rsp_valid;
    logic [BUS_WIDTH-1:0]     r_rsp_data;
    logic [1:0]               r_rsp_status;
    logic                     r_reg_valid;
    logic [ADDRESS_WIDTH-1:0] r_reg_address;
    logic                     r_reg_write;
    logic [BUS_WIDTH-1:0]     r_reg_data;
    logic [STRB_W-1:0]        r_reg_strobe;
    logic [CNT_W-1:0]         r_count;

    logic                     w_hit;
    logic                     w_done;
    logic                     w_timeout;
    logic [BUS_WIDTH-1:0]     w_or_data;
    logic [1:0]               w_or_status;
    logic                     w_accept;
    logic                     w_capture;
    logic                     w_rsp_done;
    logic [BUS_WIDTH-1:0]     w_cap_data;
    logic [1:0]               w_cap_status;

    // Collect decode/completion from all slices; simultaneous hits are ORed.
    always_comb begin
        w_hit       = |i_reg_active;
        w_done      = |(i_reg_active & i_reg_ready);
        w_or_data   = '0;
        w_or_status = '0;
        for (int i = 0; i < REGISTER_COUNT; i++) begin
            if (i_reg_active[i] && i_reg_ready[i]) begin
                w_or_data   = w_or_data   | i_reg_data[i*BUS_WIDTH +: BUS_WIDTH];
                w_or_status = w_or_status | i_reg_status[2*i +: 2];
            end
        end
    end

    assign w_timeout  = TO_EN && (r_count == CNT_LAST);
    assign w_accept   = (r_state == IDLE) && i_req_valid && r_req_ready;
    assign w_capture  = (r_state == ACCESS) && (!w_hit || w_done || w_timeout);
    assign w_rsp_done = (r_state == RESPOND) && i_rsp_ready;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_next_state = ACCESS;
            ACCESS:  if (w_capture)  w_next_state = RESPOND;
            RESPOND: if (w_rsp_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Response value to capture when the access ends: decode miss, slice
    // completion, or timeout, in that priority order.
    always_comb begin
        w_cap_status = ST_SLVERR;
        w_cap_data   = DEFAULT_READ_DATA;
        if (!w_hit) begin
            w_cap_status = ERR_EN ? ST_DECERR : ST_OKAY;
            w_cap_data   = ERR_EN ? DEFAULT_READ_DATA : '0;
        end else if (w_done) begin
            w_cap_status = w_or_status;
            if (!r_reg_write) begin
                w_cap_data = w_or_data;
            end else if (w_or_status[1]) begin
                w_cap_data = DEFAULT_READ_DATA;
            end else begin
                w_cap_data = '0;
            end
        end
    end

    // Registered handshakes, latched request fields, response and counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_status  <= '0;
            r_reg_valid   <= 1'b0;
            r_reg_address <= '0;
            r_reg_write   <= 1'b0;
            r_reg_data    <= '0;
            r_reg_strobe  <= '0;
            r_count       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready   <= 1'b0;
                        r_reg_valid   <= 1'b1;
                        r_reg_address <= i_req_address;
                        r_reg_write   <= i_req_write;
                        r_reg_data    <= i_req_data;
                        r_reg_strobe  <= i_req_strobe;
                    end else begin
                        r_req_ready   <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (w_capture) begin
                        r_reg_valid  <= 1'b0;
                        r_count      <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_data   <= w_cap_data;
                        r_rsp_status <= w_cap_status;
                    end else if (r_count != CNT_MAX) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                RESPOND: begin
                    if (w_rsp_done) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_reg_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_status  = r_rsp_status;
    assign o_reg_valid   = r_reg_valid;
    assign o_reg_address = r_reg_address;
    assign o_reg_write   = r_reg_write;
    assign o_reg_data    = r_reg_data;
    assign o_reg_strobe  = r_reg_strobe;

endmodule

// File: tb/tb_rggen_register_access_adapter.sv
// Bench for the register access adapter: two instances (error/timeout
// enabled and disabled) share one stimulus stream and a behavioural model.
module tb_rggen_register_access_adapter;

    localparam logic [31:0] DEF   = 32'hBAD0_BAD0;
    localparam int          NEVER = 99;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [7:0]  req_address = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_strobe = '0;
    logic        rsp_ready = 1'b0;
    logic [1:0]  reg_active = '0;
    logic [1:0]  reg_ready = '0;
    logic [3:0]  reg_status = '0;
    logic [63:0] reg_data = '0;

    logic        a_req_ready, a_rsp_valid, a_reg_valid, a_reg_write;
    logic [31:0] a_rsp_data, a_reg_data;
    logic [1:0]  a_rsp_status;
    logic [7:0]  a_reg_address;
    logic [3:0]  a_reg_strobe;
    logic        b_req_ready, b_rsp_valid, b_reg_valid, b_reg_write;
    logic [31:0] b_rsp_data, b_reg_data;
    logic [1:0]  b_rsp_status;
    logic [7:0]  b_reg_address;
    logic [3:0]  b_reg_strobe;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rggen_register_access_adapter #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTER_COUNT(2),
        .ERROR_STATUS(1), .TIMEOUT(4), .DEFAULT_READ_DATA(DEF)
    ) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(a_req_ready),
        .i_req_address(req_address), .i_req_write(req_write),
        .i_req_data(req_data), .i_req_strobe(req_strobe),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(a_rsp_data), .o_rsp_status(a_rsp_status),
        .o_reg_valid(a_reg_valid), .o_reg_address(a_reg_address),
        .o_reg_write(a_reg_write), .o_reg_data(a_reg_data),
        .o_reg_strobe(a_reg_strobe),
        .i_reg_active(reg_active), .i_reg_ready(reg_ready),
        .i_reg_status(reg_status), .i_reg_data(reg_data)
    );

    rggen_register_access_adapter #(
        .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTER_COUNT(2),
        .ERROR_STATUS(0), .TIMEOUT(0), .DEFAULT_READ_DATA(DEF)
    ) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(b_req_ready),
        .i_req_address(req_address), .i_req_write(req_write),
        .i_req_data(req_data), .i_req_strobe(req_strobe),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(b_rsp_data), .o_rsp_status(b_rsp_status),
        .o_reg_valid(b_reg_valid), .o_reg_address(b_reg_address),
        .o_reg_write(b_reg_write), .o_reg_data(b_reg_data),
        .o_reg_strobe(b_reg_strobe),
        .i_reg_active(reg_active), .i_reg_ready(reg_ready),
        .i_reg_status(reg_status), .i_reg_data(reg_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {status, data} from the response rules.
    function automatic logic [33:0] model(input bit es, input bit to, input logic [1:0] act,
                                          input logic wr, input logic [31:0] d0, input logic [31:0] d1,
                                          input logic [1:0] s0, input logic [1:0] s1);
        logic [1:0]  st;
        logic [31:0] d;
        if (act == 2'b00) return es ? {2'b11, DEF} : {2'b00, 32'h0};
        if (to) return {2'b10, DEF};
        st = 2'b00;
        d  = 32'h0;
        if (act[0]) begin st = st | s0; d = d | d0; end
        if (act[1]) begin st = st | s1; d = d | d1; end
        if (wr) d = st[1] ? DEF : 32'h0;
        return {st, d};
    endfunction

    // One complete transaction. stall = cycles the active slices withhold
    // ready (NEVER = forever), bp = cycles the response is backpressured.
    task automatic txn(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] sb, input logic [1:0] act, input int stall,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] s0, input logic [1:0] s1, input int bp);
        logic [33:0] ea, eb;
        int  exp_ca, exp_cb, ca, cb;
        bit  stable, hold, to_a, b_never;
        chk("req_ready_a_idle", a_req_ready, 1);
        chk("req_ready_b_idle", b_req_ready, 1);
        req_valid = 1'b1; req_address = addr; req_write = wr;
        req_data = wd; req_strobe = sb;
        reg_active = 2'b00; reg_ready = 2'b00;
        tick();
        req_valid = 1'b0;
        req_address = 8'($urandom); req_write = 1'($urandom);
        req_data = $urandom; req_strobe = 4'($urandom);
        chk("req_ready_a_busy", a_req_ready, 0);
        chk("reg_valid_a_start", a_reg_valid, 1);
        chk("reg_fields_a", {a_reg_address, a_reg_write, a_reg_data, a_reg_strobe}, {addr, wr, wd, sb});
        chk("reg_fields_b", {b_reg_address, b_reg_write, b_reg_data, b_reg_strobe}, {addr, wr, wd, sb});
        reg_active = act; reg_data = {d1, d0}; reg_status = {s1, s0};
        b_never = (act != 2'b00) && (stall == NEVER);
        to_a    = (act != 2'b00) && (stall >= 4);
        exp_ca  = (act == 2'b00) ? 1 : (to_a ? 4 : stall + 1);
        exp_cb  = (act == 2'b00) ? 1 : (b_never ? 12 : stall + 1);
        ca = 0; cb = 0; stable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            reg_ready = (c >= stall) ? act : 2'b00;
            if (a_reg_valid) ca++;
            if (b_reg_valid) cb++;
            if (a_reg_valid && ({a_reg_address, a_reg_write, a_reg_data, a_reg_strobe} !== {addr, wr, wd, sb})) stable = 1'b0;
            if (b_reg_valid && ({b_reg_address, b_reg_write, b_reg_data, b_reg_strobe} !== {addr, wr, wd, sb})) stable = 1'b0;
            tick();
            if (!a_reg_valid && !b_reg_valid) break;
        end
        if (!b_never) begin reg_active = 2'b00; reg_ready = 2'b00; end
        chk("reg_valid_cycles_a", ca, exp_ca);
        chk("reg_valid_cycles_b", cb, exp_cb);
        chk("reg_fields_stable", stable, 1);
        ea = model(1'b1, to_a, act, wr, d0, d1, s0, s1);
        eb = model(1'b0, 1'b0, act, wr, d0, d1, s0, s1);
        chk("rsp_valid_a", a_rsp_valid, 1);
        chk("rsp_status_a", a_rsp_status, ea[33:32]);
        chk("rsp_data_a", a_rsp_data, ea[31:0]);
        if (!b_never) begin
            chk("rsp_valid_b", b_rsp_valid, 1);
            chk("rsp_status_b", b_rsp_status, eb[33:32]);
            chk("rsp_data_b", b_rsp_data, eb[31:0]);
        end else begin
            chk("rsp_valid_b_no_timeout", b_rsp_valid, 0);
            chk("reg_valid_b_no_timeout", b_reg_valid, 1);
        end
        hold = 1'b1;
        for (int k = 0; k < bp; k++) begin
            tick();
            if (a_rsp_valid !== 1'b1 || a_req_ready !== 1'b0 ||
                {a_rsp_status, a_rsp_data} !== ea) hold = 1'b0;
        end
        if (bp > 0) chk("rsp_hold_a", hold, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_a_after", a_rsp_valid, 0);
        chk("req_ready_a_after", a_req_ready, 1);
        if (!b_never) chk("req_ready_b_after", b_req_ready, 1);
        else chk("reg_valid_b_still", b_reg_valid, 1);
    endtask

    initial begin
        logic [7:0]  ra;
        logic        rw;
        logic [1:0]  rac;
        // Reset state
        #1 rst = 1'b1;
        tick(); tick();
        chk("rst_req_ready_a", a_req_ready, 0);
        chk("rst_rsp_valid_a", a_rsp_valid, 0);
        chk("rst_reg_valid_a", a_reg_valid, 0);
        chk("rst_rsp_a", {a_rsp_status, a_rsp_data}, 0);
        chk("rst_fields_a", {a_reg_address, a_reg_write, a_reg_data, a_reg_strobe}, 0);
        chk("rst_req_ready_b", b_req_ready, 0);
        rst = 1'b0;
        chk("rel_req_ready_a", a_req_ready, 0);
        tick();
        chk("rel_req_ready_a_1", a_req_ready, 1);

        // Directed: single read, write with stall, unmapped, backpressure
        txn(8'h04, 1'b0, 32'h0, 4'hF, 2'b10, 0, 32'h1111_2222, 32'hDEAD_BEEF, 2'b00, 2'b00, 0);
        txn(8'h10, 1'b1, 32'hCAFE_F00D, 4'b0011, 2'b01, 3, 32'h5555_AAAA, 32'h0, 2'b00, 2'b00, 0);
        txn(8'h80, 1'b0, 32'h0, 4'hF, 2'b00, 0, 32'h1234_5678, 32'h8765_4321, 2'b00, 2'b00, 0);
        txn(8'h08, 1'b0, 32'h0, 4'hF, 2'b11, 1, 32'h1234_5678, 32'h0F0F_0000, 2'b00, 2'b00, 5);

        // Randomized traffic, no timeouts
        for (int n = 0; n < 20; n++) begin
            ra  = 8'($urandom);
            rw  = 1'($urandom);
            rac = 2'($urandom);
            txn(ra, rw, $urandom, 4'($urandom), rac, int'($urandom_range(0, 2)),
                $urandom, $urandom, 2'b00, 2'b00, int'($urandom_range(0, 3)));
        end

        // Timeout: slice active, never ready
        txn(8'h20, 1'b0, 32'h0, 4'hF, 2'b01, NEVER, 32'h0, 32'h0, 2'b00, 2'b00, 0);

        // Reset during ACCESS on both instances
        req_valid = 1'b1; req_address = 8'h30; req_write = 1'b1;
        req_data = 32'hA5A5_5A5A; req_strobe = 4'hF;
        tick();
        req_valid = 1'b0;
        chk("pre_rst_reg_valid_a", a_reg_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reg_valid_a", a_reg_valid, 0);
        chk("async_req_ready_a", a_req_ready, 0);
        chk("async_rsp_a", {a_rsp_valid, a_rsp_status, a_rsp_data}, 0);
        chk("async_fields_a", {a_reg_address, a_reg_write, a_reg_data, a_reg_strobe}, 0);
        chk("async_reg_valid_b", b_reg_valid, 0);
        chk("async_rsp_valid_b", b_rsp_valid, 0);
        tick(); tick();
        rst = 1'b0;
        reg_active = 2'b00;
        chk("rel2_req_ready_a", a_req_ready, 0);
        tick();
        chk("rel2_req_ready_a_1", a_req_ready, 1);
        chk("rel2_rsp_valid_a", a_rsp_valid, 0);
        chk("rel2_req_ready_b_1", b_req_ready, 1);

        // Operation resumes after reset
        txn(8'h44, 1'b0, 32'h0, 4'hF, 2'b01, 0, 32'h0BAD_CAFE, 32'h0, 2'b00, 2'b00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
